// File: rtl/prng_pkg.sv
// Shared definitions for the MINSTD Lehmer generator and its range-reduction consumer.
package prng_pkg;

  localparam logic [31:0] M = 32'd2147483647;
  localparam logic [31:0] A = 32'd16807;

  localparam int RAND_W_DEF = 32;
  localparam int OUT_W_DEF  = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    REL,
    CHECK,
    HOLD
  } state_t;

endpackage

// File: rtl/bit_smear.sv
// Sets every bit below the most significant set bit of the input.
module bit_smear #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] mask
);

  always_comb begin
    mask = value;
    for (int i = 1; i < W; i++) begin
      mask = mask | (value >> i);
    end
  end

endmodule

// File: rtl/prng_range.sv
// Drives the prng handshake, chains each result back as the next seed, and
// reduces results to a uniform value in [lo, hi] by mask-and-reject sampling.
module prng_range
  import prng_pkg::*;
#(
  parameter int RAND_W = RAND_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [RAND_W-1:0] init_seed,
  input  logic              en,
  input  logic [OUT_W-1:0]  cfg_lo,
  input  logic [OUT_W-1:0]  cfg_hi,
  output logic [RAND_W-1:0] prng_seed,
  output logic              prng_start,
  input  logic              prng_done,
  input  logic [RAND_W-1:0] prng_rand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  rej_cnt
);

  state_t            state, state_d;
  logic [RAND_W-1:0] seed_q, seed_d;
  logic [OUT_W-1:0]  lo_q, lo_d;
  logic [OUT_W-1:0]  span_q, span_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  mask;
  logic [OUT_W-1:0]  cand;

  bit_smear #(.W(OUT_W)) u_smear (
    .value(span_q),
    .mask (mask)
  );

  // The seed register already holds the last draw once REL completes.
  assign cand = seed_q[OUT_W-1:0] & mask;

  always_comb begin
    state_d = state;
    seed_d  = seed_q;
    lo_d    = lo_q;
    span_d  = span_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state)
      IDLE: begin
        if (seed_load) begin
          seed_d = (init_seed == '0) ? RAND_W'(1) : init_seed;
        end else if (en) begin
          lo_d   = cfg_lo;
          span_d = cfg_hi - cfg_lo;
          if (cfg_hi < cfg_lo) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (prng_done) state_d = REL;
      end
      REL: begin
        if (!prng_done) begin
          seed_d  = prng_rand;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cand <= span_q) begin
          data_d  = lo_q + cand;
          state_d = HOLD;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = en ? REQ : IDLE;
        end
      end
      HOLD: begin
        if (out_ready) state_d = en ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      seed_q <= RAND_W'(1);
      lo_q   <= '0;
      span_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_d;
      seed_q <= seed_d;
      lo_q   <= lo_d;
      span_q <= span_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign prng_seed  = seed_q;
  assign prng_start = (state == REQ);
  assign out_valid  = (state == HOLD);
  assign out_data   = data_q;
  assign cfg_err    = err_q;
  assign rej_cnt    = cnt_q;

endmodule
